wbl_key_readback: RTL and testbench
===================================

# wbl_key_readback

Read-back controller and decoder for the AES round-key bit matrix written into the DRAM CIM array by the WBL generator. It walks the six key-carrying array addresses (plain set 0/1/2, complement set 32/33/34), fetches all 16 WBL words per address through a one-outstanding read port, and rebuilds round keys rk[0..10]. The complement copies are checked against the plain copies, and padding bits are checked too. It sits between the array read-sense path and the test/verification controller.

## Interface
- TO_CYC, 255: max cycles to wait for RD_VALID before aborting (8-bit counter range, ≥1)
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  asynchronous active-low reset
- START  in  1  begin read-back; sampled only in IDLE or DONE
- BUSY  out  1  high from the cycle after START until completion
- DONE  out  1  level; high after completion until next accepted START
- RD_EN  out  1  one-cycle read request strobe
- RD_ADDR  out  6  array address of request
- RD_SEL  out  4  word index 0..15 (generator word index, not WBL port number)
- RD_DATA  in  64  returned word
- RD_VALID  in  1  RD_DATA valid; exactly one per request, any latency ≥1
- RK_SEL  in  4  round-key select 0..10 (11..15 return 0)
- RK_OUT  out  128  recovered rk[RK_SEL], combinational from buffer
- ERR_CNT  out  7  count of complement/padding mismatching words (saturates at 127)
- TIMEOUT  out  1  set when a read timed out; cleared by next accepted START

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- Sequence index s = 0..5 maps to address 0, 1, 2, 32, 33, 34. For each s, idx runs 0..15, for 96 reads total.
- IDLE/DONE + START: clear ERR_CNT, TIMEOUT, and s/idx, then go to ISSUE. The rk buffer is not cleared.
- ISSUE: assert RD_EN for one cycle with RD_ADDR and RD_SEL. Go to WAIT and load the timeout counter.
- WAIT: on RD_VALID, decode RD_DATA. Then advance idx, or wrap idx and advance s, and return to ISSUE. After s=5, idx=15, go to DONE.
- WAIT with no RD_VALID for TO_CYC cycles: set TIMEOUT and go to DONE. Buffer contents are then partial.
- Decode for word idx, column c = 0..3, row r = 0..7:
  - Source bit is w = RD_DATA[63 − 8c − r].
  - Target round is base + c, with base = 0/4/8 for address 0/1/2 (and for 32/33/34).
  - Target byte is b = 2r + (idx ≥ 8); target bit is k = 7 − (idx mod 8). Rk vector position is 120 − 8b + k.
- Plain addresses (s = 0..2): write w into the buffer. Exception: address 2, c = 3 is padding. Expected w = 0; it is not stored.
- Complement addresses (s = 3..5): compare w against the inverse of the stored bit. For address 34, c = 3 expects 1.
- A word counts as one error if any of its 32 checked bits mismatch, or if a padding bit in a plain word is wrong. ERR_CNT increments by 1 per such word.
- RD_DATA bits in columns c = 4..7 (bits 31:0) are ignored.
- RD_VALID outside WAIT is ignored.
- START while BUSY is ignored.

## Timing
- Reset values: state IDLE, BUSY 0, DONE 0, RD_EN 0, RD_ADDR 0, RD_SEL 0, ERR_CNT 0, TIMEOUT 0, rk buffer all 0.
- START at cycle t produces RD_EN at t+1. With read latency L (RD_VALID at RD_EN + L), the next RD_EN comes at RD_VALID + 1.
- Total time START to DONE = 96·(L+1) + 1 cycles. DONE and BUSY change on the same edge.
- The buffer write and ERR_CNT update land on the edge that samples RD_VALID.
- RK_OUT has zero-cycle latency from RK_SEL and the buffer.
- RSTn low at any point aborts immediately to reset values. An in-flight RD_VALID after reset is ignored.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c; array model returns golden generator words with L = 1. Expected: DONE after 193 cycles; RK_SEL 0 gives the key; RK_SEL 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; ERR_CNT 0.
- Same key with L = 5 and random extra stalls ≤ 20. Expected: identical RK_OUT; exactly 96 RD_EN pulses; RD_ADDR/RD_SEL order 0/0..15, 1/.., 2/.., 32/.., 33/.., 34/...
- Flip one bit of address-33, idx-4 word (bit 63) plus two bits of address-32, idx-0 word. Expected: ERR_CNT = 2; RK_OUT unchanged.
- Set the padding bit (address 2, c = 3, bit 39) in word idx 7. Expected: ERR_CNT = 1.
- Suppress RD_VALID for request 10 with TO_CYC = 8. Expected: TIMEOUT = 1 and DONE after 8 wait cycles. A new START clears TIMEOUT.
- Assert RSTn low in the middle of address 1. Expected: all outputs return to reset values immediately. A late RD_VALID is ignored. A new START then completes correctly.

Source files
------------

// File: rtl/wbl_key_readback_if.sv
// Read port between the key read-back controller and the CIM array read-sense path.
// One request outstanding at a time; exactly one RD_VALID answers each RD_EN.
interface wbl_key_readback_if;
  logic        RD_EN;
  logic [5:0]  RD_ADDR;
  logic [3:0]  RD_SEL;
  logic [63:0] RD_DATA;
  logic        RD_VALID;

  modport master (output RD_EN, RD_ADDR, RD_SEL, input  RD_DATA, RD_VALID);
  modport slave  (input  RD_EN, RD_ADDR, RD_SEL, output RD_DATA, RD_VALID);
endinterface

// File: rtl/wbl_key_readback.sv
// Walks the six key-carrying array addresses, rebuilds rk[0..10] from the plain copies
// and checks the complement copies and padding bits, counting bad words.
module wbl_key_readback #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  wbl_key_readback_if.master        rd_bus,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      DONE,
  input  logic [3:0]                RK_SEL,
  output logic [127:0]              RK_OUT,
  output logic [6:0]                ERR_CNT,
  output logic                      TIMEOUT
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TO_LOAD = 8'(TO_CYC - 1);

  state_t       state, state_nxt;
  logic         comp_q;        // 0: plain set 0/1/2, 1: complement set 32/33/34
  logic [1:0]   grp_q;         // address within the set, selects round base 0/4/8
  logic [3:0]   idx_q;
  logic [7:0]   to_cnt;
  logic [127:0] rk [0:10];
  logic         start_ok, rsp, last_word, word_err;
  logic         unused_low;

  // Rk bit position for word idx and row r: byte 2r+idx[3], bit 7-idx[2:0].
  function automatic logic [6:0] bit_pos(input logic [3:0] idx, input int r);
    return 7'(127 - 16*r - 8*int'(idx[3]) - int'(idx[2:0]));
  endfunction

  assign start_ok  = START && (state == S_IDLE || state == S_DONE);
  assign rsp       = (state == S_WAIT) && rd_bus.RD_VALID;
  assign last_word = comp_q && (grp_q == 2'd2) && (idx_q == 4'd15);

  assign rd_bus.RD_ADDR = {comp_q, 3'b000, grp_q};
  assign rd_bus.RD_SEL  = idx_q;

  // Columns 4..7 of every word carry no key material.
  assign unused_low = ^rd_bus.RD_DATA[31:0];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt     = state;
    rd_bus.RD_EN  = 1'b0;
    BUSY          = 1'b0;
    DONE          = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        DONE = (state == S_DONE);
        if (START) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        rd_bus.RD_EN = 1'b1;
        BUSY         = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        BUSY = 1'b1;
        if (rd_bus.RD_VALID)  state_nxt = last_word ? S_DONE : S_ISSUE;
        else if (to_cnt == 0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A word is bad if any complement bit fails to invert the stored plain bit, or any padding bit is wrong.
  always_comb begin
    word_err = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 8; r++) begin
        if (grp_q == 2'd2 && c == 3) begin
          if (rd_bus.RD_DATA[6'(63 - 8*c - r)] != comp_q) word_err = 1'b1;
        end else if (comp_q) begin
          if (rd_bus.RD_DATA[6'(63 - 8*c - r)] == rk[4'(4*int'(grp_q) + c)][bit_pos(idx_q, r)])
            word_err = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      comp_q  <= 1'b0;
      grp_q   <= 2'd0;
      idx_q   <= 4'd0;
      to_cnt  <= 8'd0;
      ERR_CNT <= 7'd0;
      TIMEOUT <= 1'b0;
    end else begin
      if (start_ok) begin
        comp_q  <= 1'b0;
        grp_q   <= 2'd0;
        idx_q   <= 4'd0;
        ERR_CNT <= 7'd0;
        TIMEOUT <= 1'b0;
      end
      if (state == S_ISSUE)
        to_cnt <= TO_LOAD;
      else if (state == S_WAIT && !rd_bus.RD_VALID) begin
        if (to_cnt == 0) TIMEOUT <= 1'b1;
        else             to_cnt  <= to_cnt - 8'd1;
      end
      if (rsp) begin
        if (word_err && ERR_CNT != 7'd127) ERR_CNT <= ERR_CNT + 7'd1;
        if (!last_word) begin
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            if (grp_q == 2'd2) begin
              grp_q  <= 2'd0;
              comp_q <= 1'b1;
            end else begin
              grp_q <= grp_q + 2'd1;
            end
          end
        end
      end
    end
  end

  // NOTE: the key buffer is reset explicitly because RK_OUT must read all-zero after reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else if (rsp && !comp_q) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 8; r++) begin
          if (!(grp_q == 2'd2 && c == 3))
            rk[4'(4*int'(grp_q) + c)][bit_pos(idx_q, r)] <= rd_bus.RD_DATA[6'(63 - 8*c - r)];
        end
      end
    end
  end

  assign RK_OUT = (RK_SEL <= 4'd10) ? rk[RK_SEL] : '0;

endmodule

// File: tb/tb_wbl_key_readback.sv
// Bench for wbl_key_readback: an AES key-expansion model feeds an array model that
// serves generator words with configurable latency, stalls, bit flips and drops.
module tb_wbl_key_readback;

  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [63:0]  B63  = 64'h8000_0000_0000_0000;

  typedef struct {
    int          sa; int ia; logic [63:0] ma;
    int          sb; int ib; logic [63:0] mb;
    int          exp_err;
  } vec_t;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic         start = 1'b0, rd_valid = 1'b0, use_to = 1'b0;
  logic [63:0]  rd_data = '0;
  logic [3:0]   rk_sel = '0;

  logic         m_busy, m_done, m_to, t_busy, t_done, t_to;
  logic [127:0] m_rk, t_rk;
  logic [6:0]   m_err, t_err;

  wbl_key_readback_if bus_m();
  wbl_key_readback_if bus_t();

  assign bus_m.RD_DATA  = rd_data;
  assign bus_t.RD_DATA  = rd_data;
  assign bus_m.RD_VALID = rd_valid & ~use_to;
  assign bus_t.RD_VALID = rd_valid & use_to;

  wbl_key_readback dut (
    .CLK(CLK), .RSTn(RSTn), .rd_bus(bus_m), .START(start & ~use_to),
    .BUSY(m_busy), .DONE(m_done), .RK_SEL(rk_sel), .RK_OUT(m_rk),
    .ERR_CNT(m_err), .TIMEOUT(m_to)
  );

  wbl_key_readback #(.TO_CYC(8)) dut_to (
    .CLK(CLK), .RSTn(RSTn), .rd_bus(bus_t), .START(start & use_to),
    .BUSY(t_busy), .DONE(t_done), .RK_SEL(rk_sel), .RK_OUT(t_rk),
    .ERR_CNT(t_err), .TIMEOUT(t_to)
  );

  logic         o_busy, o_done, o_to, o_rd_en;
  logic [127:0] o_rk;
  logic [6:0]   o_err;
  logic [5:0]   o_addr;
  logic [3:0]   o_sel;
  assign o_busy  = use_to ? t_busy : m_busy;
  assign o_done  = use_to ? t_done : m_done;
  assign o_to    = use_to ? t_to   : m_to;
  assign o_rk    = use_to ? t_rk   : m_rk;
  assign o_err   = use_to ? t_err  : m_err;
  assign o_rd_en = use_to ? bus_t.RD_EN   : bus_m.RD_EN;
  assign o_addr  = use_to ? bus_t.RD_ADDR : bus_m.RD_ADDR;
  assign o_sel   = use_to ? bus_t.RD_SEL  : bus_m.RD_SEL;

  always #5 CLK = ~CLK;

  int           n_checks = 0, n_fail = 0;
  logic [7:0]   sbox [0:255];
  logic [127:0] rk_m [0:10];
  logic [63:0]  flip [0:5][0:15];
  int           done_k, drop_k, n_req, order_bad;
  vec_t         vecs [0:6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AES key-expansion reference ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_model();
    logic [7:0]  inv, rcon;
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- array model ----------------
  function automatic logic [5:0] addr_of(input int s);
    return (s < 3) ? 6'(s) : 6'(s + 29);
  endfunction

  // Word the WBL generator writes for sequence s, word idx i (low half is don't-care filler).
  function automatic logic [63:0] golden(input int s, input int i);
    logic [63:0] wd;
    int          g, b, k;
    g  = s % 3;
    wd = {32'h0, $urandom()};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 8; r++) begin
        if (g == 2 && c == 3) wd[63 - 8*c - r] = (s >= 3);
        else begin
          b = 2*r + ((i >= 8) ? 1 : 0);
          k = 7 - i % 8;
          wd[63 - 8*c - r] = rk_m[4*g + c][120 - 8*b + k] ^ (s >= 3);
        end
      end
    end
    return wd;
  endfunction

  task automatic clear_flips();
    for (int s = 0; s < 6; s++) for (int i = 0; i < 16; i++) flip[s][i] = '0;
  endtask

  // Starts a read-back and serves requests until DONE, or returns right after request stop_req issues.
  task automatic run(input int lat, input int stall_max, input int drop_req, input int stop_req);
    int k, cnt, cs, ci;
    bit pending, drop, fin;
    k = 0; cnt = 0; cs = 0; ci = 0; pending = 0; drop = 0; fin = 0;
    n_req = 0; order_bad = 0; done_k = -1; drop_k = -1;
    @(negedge CLK); start = 1'b1;
    while (k < 20000 && !fin) begin
      @(negedge CLK);
      k++;
      start = 1'b0; rd_valid = 1'b0;
      if (o_done) begin
        done_k = k; fin = 1;
      end else if (o_rd_en) begin
        if (pending || n_req >= 96) order_bad++;
        else if (o_addr != addr_of(n_req / 16) || o_sel != 4'(n_req % 16)) order_bad++;
        cs = (n_req / 16) % 6; ci = n_req % 16;
        drop = (n_req == drop_req);
        if (drop) drop_k = k;
        pending = 1;
        cnt = lat + ((stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0);
        if (n_req == stop_req) fin = 1;
        n_req++;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          pending = 0;
          if (!drop) begin
            rd_valid = 1'b1;
            rd_data  = golden(cs, ci) ^ flip[cs][ci];
          end
        end
      end
    end
    if (!fin) check("run cycle budget", 1'b0, 1'b1);
  endtask

  task automatic check_rk(input string tag);
    for (int s = 0; s < 16; s++) begin
      rk_sel = 4'(s);
      #1;
      check($sformatf("%s rk_out[%0d]", tag, s), o_rk, (s <= 10) ? rk_m[s] : 128'h0);
    end
  endtask

  task automatic check_results(input string tag, input int exp_err);
    check({tag, " rd_en pulses"}, n_req, 96);
    check({tag, " request order"}, order_bad, 0);
    check({tag, " err_cnt"}, o_err, exp_err);
    check({tag, " timeout"}, o_to, 0);
    check({tag, " busy"}, o_busy, 0);
    check({tag, " done"}, o_done, 1);
    check_rk(tag);
  endtask

  initial begin
    int lat, stall, nflips, s, i, bitn, exp;
    logic [63:0] relevant;

    vecs[0] = '{0, 0, 64'h0,                        0, 0,  64'h0,          0};
    vecs[1] = '{4, 4, B63,                          3, 0,  B63 | (B63>>13), 2};
    vecs[2] = '{2, 7, 64'h0000_0080_0000_0000,      0, 0,  64'h0,          1};
    vecs[3] = '{5, 15, 64'h0000_0001_0000_0000,     0, 0,  64'h0,          1};
    vecs[4] = '{1, 3, 64'h0000_0000_FFFF_FFFF,      3, 9,  64'h0000_0000_8001_0000, 0};
    vecs[5] = '{2, 0, 64'h0000_0001_0000_0000,      5, 0,  64'h0000_0100_0000_0000, 2};
    vecs[6] = '{3, 15, B63,                         3, 15, B63 >> 1,       1};

    build_model();
    clear_flips();

    // Reset values
    #1;
    check("reset busy", o_busy, 0);
    check("reset done", o_done, 0);
    check("reset rd_en", o_rd_en, 0);
    check("reset rd_addr", o_addr, 0);
    check("reset rd_sel", o_sel, 0);
    check("reset err_cnt", o_err, 0);
    check("reset timeout", o_to, 0);
    check("reset rk_out", o_rk, 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;

    // FIPS-197 key, L = 1
    run(1, 0, -1, -1);
    check("fips done cycle", done_k, 193);
    rk_sel = 4'd0;  #1; check("fips rk0 key", o_rk, KEY);
    rk_sel = 4'd10; #1; check("fips rk10", o_rk, RK10);
    check_results("fips", 0);

    // L = 5 with random stalls
    run(5, 20, -1, -1);
    check_results("stall", 0);

    // Table of corrupted-word scenarios
    for (int v = 0; v < 7; v++) begin
      clear_flips();
      flip[vecs[v].sa][vecs[v].ia] ^= vecs[v].ma;
      flip[vecs[v].sb][vecs[v].ib] ^= vecs[v].mb;
      run(1, 0, -1, -1);
      check($sformatf("vec%0d done cycle", v), done_k, 193);
      check_results($sformatf("vec%0d", v), vecs[v].exp_err);
    end

    // Randomized corruption, latency and stalls
    for (int it = 0; it < 4; it++) begin
      clear_flips();
      nflips = $urandom_range(4, 0);
      for (int f = 0; f < nflips; f++) begin
        s = $urandom_range(5, 0);
        i = $urandom_range(15, 0);
        if (s >= 3)                             bitn = $urandom_range(63, 0);
        else if (s == 2 && $urandom_range(1, 0) == 1) bitn = $urandom_range(39, 32);
        else                                    bitn = $urandom_range(31, 0);
        flip[s][i][bitn] = ~flip[s][i][bitn];
      end
      exp = 0;
      for (int a = 0; a < 6; a++) begin
        relevant = (a >= 3) ? 64'hFFFF_FFFF_0000_0000 : (a == 2) ? 64'h0000_00FF_0000_0000 : 64'h0;
        for (int w = 0; w < 16; w++) if ((flip[a][w] & relevant) != 0) exp++;
      end
      lat   = $urandom_range(6, 1);
      stall = ($urandom_range(1, 0) == 1) ? 20 : 0;
      run(lat, stall, -1, -1);
      if (stall == 0) check($sformatf("rand%0d done cycle", it), done_k, 96*(lat+1) + 1);
      check_results($sformatf("rand%0d", it), exp);
    end
    clear_flips();

    // Timeout on request 10 with TO_CYC = 8, then a clean restart clears it
    use_to = 1'b1;
    run(1, 0, 10, -1);
    check("to timeout", o_to, 1);
    check("to done", o_done, 1);
    check("to wait cycles", done_k - drop_k, 9);
    check("to requests", n_req, 11);
    run(1, 0, -1, -1);
    check("to restart done cycle", done_k, 193);
    check_results("to restart", 0);
    use_to = 1'b0;

    // Reset in the middle of address 1, then a late RD_VALID
    run(1, 0, -1, 20);
    RSTn = 1'b0;
    rk_sel = 4'd0;
    #1;
    check("midrst busy", o_busy, 0);
    check("midrst done", o_done, 0);
    check("midrst rd_en", o_rd_en, 0);
    check("midrst rd_addr", o_addr, 0);
    check("midrst rd_sel", o_sel, 0);
    check("midrst err_cnt", o_err, 0);
    check("midrst timeout", o_to, 0);
    check("midrst rk_out", o_rk, 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    rd_valid = 1'b1;
    rd_data  = golden(1, 4);
    @(negedge CLK);
    rd_valid = 1'b0;
    @(negedge CLK);
    check("late valid busy", o_busy, 0);
    check("late valid done", o_done, 0);
    check("late valid rd_en", o_rd_en, 0);
    check("late valid rk_out", o_rk, 0);
    run(1, 0, -1, -1);
    check("after rst done cycle", done_k, 193);
    check_results("after rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
